// File: rtl/wm_cycle_sequencer_if.sv
// rtl/wm_cycle_sequencer_if.sv - Programme control and status bundle for the wash cycle sequencer.
// The door_closed/door_locked pair exists only when WM_DOOR_LOCK_EN is defined.
interface wm_cycle_sequencer_if #(
    parameter int TW = 5
);
    logic          start;
    logic          pause;
    logic          abort;
    logic [TW-1:0] wash_time;
    logic [TW-1:0] rinse_time;
    logic [TW-1:0] spin_time;
    logic          busy;
    logic [2:0]    phase;
    logic [TW-1:0] phase_remaining;
    logic [TW+2:0] remaining;
    logic          motor_on;
    logic          water_valve;
    logic          done;
`ifdef WM_DOOR_LOCK_EN
    logic          door_closed;
    logic          door_locked;

    modport master (
        output start, pause, abort, wash_time, rinse_time, spin_time, door_closed,
        input  busy, phase, phase_remaining, remaining, motor_on, water_valve, done, door_locked
    );
    modport slave (
        input  start, pause, abort, wash_time, rinse_time, spin_time, door_closed,
        output busy, phase, phase_remaining, remaining, motor_on, water_valve, done, door_locked
    );
`else
    modport master (
        output start, pause, abort, wash_time, rinse_time, spin_time,
        input  busy, phase, phase_remaining, remaining, motor_on, water_valve, done
    );
    modport slave (
        input  start, pause, abort, wash_time, rinse_time, spin_time,
        output busy, phase, phase_remaining, remaining, motor_on, water_valve, done
    );
`endif
endinterface

// File: rtl/wm_cycle_sequencer.sv
// rtl/wm_cycle_sequencer.sv - WASH/RINSE/SPIN sequencer with minute prescaler and registered actuators.
// Optional door interlock enabled by defining WM_DOOR_LOCK_EN.
module wm_cycle_sequencer #(
    parameter int TICK_DIV = 4,
    parameter int TW       = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    wm_cycle_sequencer_if.slave   bus
);
    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WASH  = 3'd1,
        S_RINSE = 3'd2,
        S_SPIN  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t        state, next_state;
    logic [TW-1:0] wash_q, rinse_q, spin_q, prem;
    logic [TW+2:0] rem;
    logic [PW-1:0] presc;
    logic [2:0]    phase_q;
    logic          busy_q, motor_q, valve_q, done_q, door_locked_q;
    logic          running, next_running, door_ok, hold_in, go, adv, tick, last;

    // First later phase with a nonzero time; zero-time phases are skipped entirely.
    function automatic state_t next_phase(state_t cur, logic [TW-1:0] w, logic [TW-1:0] r,
                                          logic [TW-1:0] s);
        if (cur == S_IDLE && w != '0) return S_WASH;
        if ((cur == S_IDLE || cur == S_WASH) && r != '0) return S_RINSE;
        if (cur != S_SPIN && s != '0) return S_SPIN;
        return S_DONE;
    endfunction

    function automatic logic [TW-1:0] time_of(state_t st, logic [TW-1:0] w, logic [TW-1:0] r,
                                              logic [TW-1:0] s);
        case (st)
            S_WASH:  return w;
            S_RINSE: return r;
            S_SPIN:  return s;
            default: return '0;
        endcase
    endfunction

    always_comb begin
        running = (state == S_WASH) || (state == S_RINSE) || (state == S_SPIN);
`ifdef WM_DOOR_LOCK_EN
        door_ok = bus.door_closed;
        hold_in = bus.pause || !bus.door_closed;
`else
        door_ok = 1'b1;
        hold_in = bus.pause;
`endif
        go   = (state == S_IDLE) && bus.start && !bus.abort && door_ok;
        adv  = running && !bus.abort && !hold_in;
        tick = adv && (presc == PRESC_LAST);
        last = tick && (prem <= TW'(1));
        next_state = state;
        case (state)
            S_IDLE:                 if (go) next_state = next_phase(S_IDLE, bus.wash_time,
                                                                    bus.rinse_time, bus.spin_time);
            S_WASH, S_RINSE, S_SPIN: begin
                if (bus.abort)  next_state = S_IDLE;
                else if (last)  next_state = next_phase(state, wash_q, rinse_q, spin_q);
            end
            default:                next_state = S_IDLE;
        endcase
        next_running = (next_state == S_WASH) || (next_state == S_RINSE) || (next_state == S_SPIN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            wash_q        <= '0;
            rinse_q       <= '0;
            spin_q        <= '0;
            prem          <= '0;
            rem           <= '0;
            presc         <= '0;
            phase_q       <= '0;
            busy_q        <= 1'b0;
            motor_q       <= 1'b0;
            valve_q       <= 1'b0;
            done_q        <= 1'b0;
            door_locked_q <= 1'b0;
        end else begin
            state         <= next_state;
            phase_q       <= next_state;
            busy_q        <= next_running;
            done_q        <= (next_state == S_DONE);
            door_locked_q <= next_running || (next_state == S_DONE);
            motor_q       <= ((next_state == S_WASH) || (next_state == S_SPIN)) && !hold_in;
            valve_q       <= ((next_state == S_WASH) || (next_state == S_RINSE)) && !hold_in;
            if (go) begin
                wash_q  <= bus.wash_time;
                rinse_q <= bus.rinse_time;
                spin_q  <= bus.spin_time;
                rem     <= (TW+3)'(bus.wash_time) + (TW+3)'(bus.rinse_time)
                         + (TW+3)'(bus.spin_time);
                prem    <= time_of(next_state, bus.wash_time, bus.rinse_time, bus.spin_time);
                presc   <= '0;
            end else if (!next_running) begin
                rem   <= '0;
                prem  <= '0;
                presc <= '0;
            end else if (adv) begin
                if (tick) begin
                    presc <= '0;
                    rem   <= rem - 1'b1;
                    prem  <= last ? time_of(next_state, wash_q, rinse_q, spin_q) : prem - 1'b1;
                end else begin
                    presc <= presc + 1'b1;
                end
            end
        end
    end

    assign bus.busy            = busy_q;
    assign bus.phase           = phase_q;
    assign bus.phase_remaining = prem;
    assign bus.remaining       = rem;
    assign bus.motor_on        = motor_q;
    assign bus.water_valve     = valve_q;
    assign bus.done            = done_q;
`ifdef WM_DOOR_LOCK_EN
    assign bus.door_locked     = door_locked_q;
`else
    logic unused_lock;
    assign unused_lock = door_locked_q;
`endif
endmodule
